// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared state encoding and helpers for the count sequencer.
package count_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A sequence is in flight while it is counting or frozen by pause.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/count_sequencer_prescale_tick.sv
// prescale_tick: prescaler counter that raises an advance strobe every cmp+1
// enabled clocks. A synchronous clear restarts the division from zero.
module prescale_tick
    import count_sequencer_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] cmp,
    output logic                  advance
);

    logic [PRESCALE_W-1:0] cnt_r;
    logic [PRESCALE_W-1:0] cnt_s;
    logic                  advance_s;

    // Next prescaler value and advance strobe; clear beats enable.
    always_comb begin
        cnt_s     = cnt_r;
        advance_s = 1'b0;
        if (clr) begin
            cnt_s = {PRESCALE_W{1'b0}};
        end else if (en) begin
            if (cnt_r == cmp) begin
                advance_s = 1'b1;
                cnt_s     = {PRESCALE_W{1'b0}};
            end else begin
                cnt_s = cnt_r + PRESCALE_W'(1'b1);
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end

    assign advance = advance_s;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: start/pause/stop/terminal-count sequencing of a W-bit
// up-counter with a programmable prescaler, one-shot or periodic.
// Optional feature macro: COUNT_SEQUENCER_IRQ_EN adds a sticky irq flag
// (set by done, cleared by irq_clr, set wins).
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int W          = 3,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic [W-1:0]          limit,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [W-1:0]          count,
    output logic                  tick,
    output logic                  done,
    output logic                  busy,
    output logic [STATE_W-1:0]    state
`ifdef COUNT_SEQUENCER_IRQ_EN
    ,
    output logic                  irq,
    input  logic                  irq_clr
`endif
);

    state_t                state_r;
    state_t                state_s;
    logic [W-1:0]          count_r;
    logic [W-1:0]          count_s;
    logic                  armed_r;
    logic                  armed_s;
    logic                  tick_r;
    logic                  tick_s;
    logic                  done_r;
    logic                  done_s;
    logic                  busy_r;
    logic [W-1:0]          limit_r;
    logic                  mode_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic                  presc_en_s;
    logic                  presc_clr_s;
    logic                  advance_s;

    // The first enabled RUN clock after a start only arms the prescaler, which
    // places the first advance prescale+1 clocks after the first RUN clock.
    assign presc_en_s  = (state_r == ST_RUN) && armed_r && !pause && !start && !stop;
    assign presc_clr_s = start || stop;

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (presc_en_s),
        .clr     (presc_clr_s),
        .cmp     (prescale_r),
        .advance (advance_s)
    );

    // Next-state, next-count and strobe decode; stop > start > pause.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        armed_s = armed_r;
        tick_s  = 1'b0;
        done_s  = 1'b0;
        if (stop) begin
            state_s = ST_IDLE;
            count_s = {W{1'b0}};
            armed_s = 1'b0;
        end else if (start) begin
            state_s = ST_RUN;
            count_s = {W{1'b0}};
            armed_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    count_s = {W{1'b0}};
                end
                ST_RUN: begin
                    if (pause) begin
                        state_s = ST_PAUSE;
                    end else if (!armed_r) begin
                        armed_s = 1'b1;
                    end else if (advance_s) begin
                        tick_s = 1'b1;
                        if (count_r != limit_r) begin
                            count_s = count_r + W'(1'b1);
                        end else begin
                            done_s = 1'b1;
                            if (mode_r) begin
                                count_s = {W{1'b0}};
                            end else begin
                                state_s = ST_DONE;
                            end
                        end
                    end else begin
                        count_s = count_r;
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    count_s = limit_r;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = {W{1'b0}};
                    armed_s = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, count and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            count_r <= {W{1'b0}};
            armed_r <= 1'b0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            armed_r <= armed_s;
            tick_r  <= tick_s;
            done_r  <= done_s;
            busy_r  <= is_busy(state_s);
        end
    end

    // Configuration captured only on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limit_r    <= {W{1'b0}};
            mode_r     <= 1'b0;
            prescale_r <= {PRESCALE_W{1'b0}};
        end else if (start && !stop) begin
            limit_r    <= limit;
            mode_r     <= mode;
            prescale_r <= prescale;
        end else begin
            limit_r    <= limit_r;
            mode_r     <= mode_r;
            prescale_r <= prescale_r;
        end
    end

`ifdef COUNT_SEQUENCER_IRQ_EN
    logic irq_r;

    // Sticky terminal flag; a done in the same cycle as irq_clr keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else if (done_r) begin
            irq_r <= 1'b1;
        end else if (irq_clr) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    assign count = count_r;
    assign tick  = tick_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign state = state_r;

endmodule
